// File: rtl/tl_rx_error_check_ctrl.sv
// tl_rx_error_check_ctrl: sequences RX TLP error checkers, applies error precedence, issues drop verdict and error message request
module tl_rx_error_check_ctrl #(
  parameter int CNT_W       = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             hdr_valid,
  output logic             hdr_ready,
  input  logic             hdr_ep,
  input  logic             cfg_poisoned_en,
  input  logic [3:0]       cfg_err_mask,
  output logic             chk_en,
  output logic             chk_ep,
  output logic             poisoned_en,
  input  logic             malformed_error,
  input  logic             ecrc_error,
  input  logic             ur_error,
  input  logic             poisoned_error,
  output logic             tlp_done,
  output logic             tlp_drop,
  output logic             err_msg_req,
  output logic [1:0]       err_msg_type,
  input  logic             err_msg_ack,
  output logic [3:0]       err_status,
  input  logic [3:0]       err_status_clr,
  output logic             msg_lost,
  output logic [CNT_W-1:0] poison_cnt
);
  localparam int TW = $clog2(ACK_TIMEOUT);
  typedef enum logic [1:0] {IDLE, CHECK, DECIDE, REPORT} state_t;
  state_t        state;
  logic          pen_l;
  logic [3:0]    res;
  logic [TW-1:0] timer;
  logic          win_masked, report, expire, lost_set;
  logic [1:0]    win_type;
  // res bit order {poison,ur,ecrc,malformed}; lowest set bit wins
  always_comb begin
    win_type   = res[0] ? 2'b11 : 2'b10;
    win_masked = res[0] ? cfg_err_mask[0] : res[1] ? cfg_err_mask[1] :
                 res[2] ? cfg_err_mask[2] : cfg_err_mask[3];
    report     = |res & ~win_masked;
    expire     = timer == TW'(ACK_TIMEOUT - 1);
    lost_set   = (state == REPORT) & ~err_msg_ack & expire;
  end
  assign poisoned_en = chk_en & pen_l;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      hdr_ready    <= 1'b0;
      chk_en       <= 1'b0;
      chk_ep       <= 1'b0;
      pen_l        <= 1'b0;
      res          <= '0;
      tlp_done     <= 1'b0;
      tlp_drop     <= 1'b0;
      err_msg_req  <= 1'b0;
      err_msg_type <= 2'b00;
      err_status   <= '0;
      msg_lost     <= 1'b0;
      poison_cnt   <= '0;
      timer        <= '0;
    end else begin
      chk_en     <= 1'b0;
      tlp_done   <= 1'b0;
      tlp_drop   <= 1'b0;
      err_status <= (err_status & ~err_status_clr) | (state == DECIDE ? res : 4'b0);
      msg_lost   <= (msg_lost & ~err_status_clr[0]) | lost_set;
      case (state)
        IDLE: begin
          hdr_ready <= 1'b1;
          if (hdr_valid && hdr_ready) begin
            chk_ep    <= hdr_ep;
            pen_l     <= cfg_poisoned_en;
            chk_en    <= 1'b1;
            hdr_ready <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          res      <= {poisoned_error & pen_l, ur_error, ecrc_error, malformed_error};
          tlp_done <= 1'b1;
          tlp_drop <= malformed_error | ecrc_error | ur_error | (poisoned_error & pen_l);
          state    <= DECIDE;
        end
        DECIDE: begin
          if (res[3] && !(&poison_cnt)) poison_cnt <= poison_cnt + 1'b1;
          timer <= '0;
          if (report) begin
            err_msg_req  <= 1'b1;
            err_msg_type <= win_type;
            state        <= REPORT;
          end else begin
            hdr_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        REPORT: begin
          if (err_msg_ack || expire) begin
            err_msg_req <= 1'b0;
            hdr_ready   <= 1'b1;
            state       <= IDLE;
          end else timer <= timer + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tl_rx_error_check_ctrl.sv
// tb_tl_rx_error_check_ctrl: directed scenario bench for the RX error-check sequencer
module tb_tl_rx_error_check_ctrl;
  localparam int CW = 2;
  localparam int TO = 8;
  logic clk = 0, arst_n = 0;
  logic hdr_valid = 0, hdr_ep = 0, cfg_poisoned_en = 1;
  logic [3:0] cfg_err_mask = 0, err_status_clr = 0;
  logic malformed_error = 0, ecrc_error = 0, ur_error = 0, poisoned_error = 0, err_msg_ack = 0;
  logic hdr_ready, chk_en, chk_ep, poisoned_en, tlp_done, tlp_drop, err_msg_req, msg_lost;
  logic [1:0] err_msg_type;
  logic [3:0] err_status;
  logic [CW-1:0] poison_cnt;
  int pass_cnt = 0, total = 0;

  tl_rx_error_check_ctrl #(.CNT_W(CW), .ACK_TIMEOUT(TO)) dut (
    .clk(clk), .arst_n(arst_n), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_ep(hdr_ep),
    .cfg_poisoned_en(cfg_poisoned_en), .cfg_err_mask(cfg_err_mask), .chk_en(chk_en), .chk_ep(chk_ep),
    .poisoned_en(poisoned_en), .malformed_error(malformed_error), .ecrc_error(ecrc_error),
    .ur_error(ur_error), .poisoned_error(poisoned_error), .tlp_done(tlp_done), .tlp_drop(tlp_drop),
    .err_msg_req(err_msg_req), .err_msg_type(err_msg_type), .err_msg_ack(err_msg_ack),
    .err_status(err_status), .err_status_clr(err_status_clr), .msg_lost(msg_lost), .poison_cnt(poison_cnt));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // res order {poison,ur,ecrc,malformed}; returns in the CHECK cycle
  task automatic start(input logic ep, input logic pen, input logic [3:0] r);
    hdr_valid = 1; hdr_ep = ep; cfg_poisoned_en = pen;
    {poisoned_error, ur_error, ecrc_error, malformed_error} = r;
    tick();
    hdr_valid = 0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (hdr_ready !== 1'b0) $display("FAIL rst_hdr_ready got %b exp 0", hdr_ready); else pass_cnt++;
    total++; if (err_msg_req !== 1'b0) $display("FAIL rst_req got %b exp 0", err_msg_req); else pass_cnt++;
    total++; if ({err_status, poison_cnt, msg_lost} !== '0) $display("FAIL rst_regs got %h exp 0", {err_status, poison_cnt, msg_lost}); else pass_cnt++;
    tick(); arst_n = 1; tick();
    total++; if (hdr_ready !== 1'b1) $display("FAIL idle_hdr_ready got %b exp 1", hdr_ready); else pass_cnt++;
  endtask

  task automatic test_clean();
    start(0, 1, 4'b0000);
    total++; if ({chk_en, hdr_ready, poisoned_en, chk_ep} !== 4'b1010) $display("FAIL clean_check got %b exp 1010", {chk_en, hdr_ready, poisoned_en, chk_ep}); else pass_cnt++;
    tick();
    total++; if ({tlp_done, tlp_drop, chk_en} !== 3'b100) $display("FAIL clean_decide got %b exp 100", {tlp_done, tlp_drop, chk_en}); else pass_cnt++;
    tick();
    total++; if ({err_msg_req, hdr_ready, tlp_done} !== 3'b010) $display("FAIL clean_after got %b exp 010", {err_msg_req, hdr_ready, tlp_done}); else pass_cnt++;
  endtask

  task automatic test_poison_report();
    start(1, 1, 4'b1000);
    total++; if ({chk_ep, poisoned_en} !== 2'b11) $display("FAIL poison_ep got %b exp 11", {chk_ep, poisoned_en}); else pass_cnt++;
    tick();
    total++; if ({tlp_done, tlp_drop} !== 2'b11) $display("FAIL poison_drop got %b exp 11", {tlp_done, tlp_drop}); else pass_cnt++;
    tick();
    total++; if ({err_msg_req, err_msg_type, hdr_ready} !== 4'b1100) $display("FAIL poison_req got %b exp 1100", {err_msg_req, err_msg_type, hdr_ready}); else pass_cnt++;
    total++; if ({err_status, poison_cnt} !== {4'b1000, 2'd1}) $display("FAIL poison_stat got %h exp %h", {err_status, poison_cnt}, {4'b1000, 2'd1}); else pass_cnt++;
    tick(); tick();
    total++; if (err_msg_req !== 1'b1) $display("FAIL poison_hold got %b exp 1", err_msg_req); else pass_cnt++;
    err_msg_ack = 1; tick(); err_msg_ack = 0;
    total++; if ({err_msg_req, hdr_ready, msg_lost} !== 3'b010) $display("FAIL poison_ack got %b exp 010", {err_msg_req, hdr_ready, msg_lost}); else pass_cnt++;
    err_status_clr = 4'hf; tick(); err_status_clr = 0;
    total++; if (err_status !== 4'b0000) $display("FAIL status_clr got %b exp 0000", err_status); else pass_cnt++;
  endtask

  task automatic test_precedence();
    start(1, 1, 4'b1001);
    tick(); tick();
    total++; if ({err_msg_req, err_msg_type} !== 3'b111) $display("FAIL prec_type got %b exp 111", {err_msg_req, err_msg_type}); else pass_cnt++;
    total++; if ({err_status, poison_cnt} !== {4'b1001, 2'd2}) $display("FAIL prec_stat got %h exp %h", {err_status, poison_cnt}, {4'b1001, 2'd2}); else pass_cnt++;
    err_msg_ack = 1; tick(); err_msg_ack = 0;
    err_status_clr = 4'hf; tick(); err_status_clr = 0;
  endtask

  task automatic test_masked_back_to_back();
    cfg_err_mask = 4'b0010;
    start(0, 1, 4'b0010);
    tick();
    total++; if ({tlp_done, tlp_drop} !== 2'b11) $display("FAIL mask_drop got %b exp 11", {tlp_done, tlp_drop}); else pass_cnt++;
    err_status_clr = 4'b0010;
    tick();
    err_status_clr = 0;
    total++; if ({err_msg_req, hdr_ready, err_status} !== 6'b010010) $display("FAIL mask_noreq got %b exp 010010", {err_msg_req, hdr_ready, err_status}); else pass_cnt++;
    start(0, 1, 4'b0000);
    total++; if ({chk_en, hdr_ready} !== 2'b10) $display("FAIL b2b_accept got %b exp 10", {chk_en, hdr_ready}); else pass_cnt++;
    tick(); tick();
    cfg_err_mask = 0;
    err_status_clr = 4'hf; tick(); err_status_clr = 0;
  endtask

  task automatic test_timeout();
    int n = 0;
    start(1, 1, 4'b1000);
    tick(); tick();
    while (err_msg_req === 1'b1 && n < 100) begin n++; tick(); end
    total++; if (n !== TO) $display("FAIL timeout_len got %0d exp %0d", n, TO); else pass_cnt++;
    total++; if ({msg_lost, hdr_ready, poison_cnt} !== {2'b11, 2'd3}) $display("FAIL timeout_lost got %b exp 1111", {msg_lost, hdr_ready, poison_cnt}); else pass_cnt++;
    err_status_clr = 4'b0001; tick(); err_status_clr = 0;
    total++; if ({msg_lost, err_status} !== 5'b01000) $display("FAIL lost_clr got %b exp 01000", {msg_lost, err_status}); else pass_cnt++;
  endtask

  task automatic test_ack_at_expiry();
    start(1, 1, 4'b1000);
    tick(); tick();
    for (int i = 0; i < TO - 1; i++) tick();
    err_msg_ack = 1; tick(); err_msg_ack = 0;
    total++; if ({err_msg_req, msg_lost} !== 2'b00) $display("FAIL ack_expiry got %b exp 00", {err_msg_req, msg_lost}); else pass_cnt++;
    total++; if (poison_cnt !== 2'd3) $display("FAIL cnt_sat got %0d exp 3", poison_cnt); else pass_cnt++;
  endtask

  task automatic test_poison_disabled();
    start(1, 0, 4'b0000);
    total++; if ({chk_en, chk_ep, poisoned_en} !== 3'b110) $display("FAIL pdis_check got %b exp 110", {chk_en, chk_ep, poisoned_en}); else pass_cnt++;
    tick();
    total++; if ({tlp_done, tlp_drop} !== 2'b10) $display("FAIL pdis_fwd got %b exp 10", {tlp_done, tlp_drop}); else pass_cnt++;
    tick();
    total++; if (err_msg_req !== 1'b0) $display("FAIL pdis_noreq got %b exp 0", err_msg_req); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    start(1, 1, 4'b1000);
    tick(); tick();
    total++; if (err_msg_req !== 1'b1) $display("FAIL ar_req got %b exp 1", err_msg_req); else pass_cnt++;
    #2 arst_n = 0; #1;
    total++; if ({err_msg_req, hdr_ready, poison_cnt, err_status} !== '0) $display("FAIL ar_drop got %b exp 0", {err_msg_req, hdr_ready, poison_cnt, err_status}); else pass_cnt++;
    tick(); arst_n = 1; tick(); tick();
    total++; if ({err_msg_req, hdr_ready} !== 2'b01) $display("FAIL ar_idle got %b exp 01", {err_msg_req, hdr_ready}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_poison_report();
    test_precedence();
    test_masked_back_to_back();
    test_timeout();
    test_ack_at_expiry();
    test_poison_disabled();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
